// File: rtl/apb_master.sv
// APB3 initiator: turns one valid/ready request into a SETUP/ACCESS transfer
// and returns read data plus error/timeout status on a valid/ready response.
//
// Ports:
//   clk_i, rstn_i           clock, async active-low reset
//   req_valid_i/req_ready_o request handshake (accepted only in IDLE)
//   req_addr_i/we_i/wdata_i request payload
//   rsp_valid_o/rsp_ready_i response handshake (held until consumed)
//   rsp_rdata_o/err_o/timeout_o response payload
//   PADDR..PENABLE          APB requester outputs
//   PRDATA/PREADY/PSLVERR   APB completer inputs
//
// Parameter TIMEOUT bounds the ACCESS phase in cycles; 0 disables it.
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_we_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic        to_hit;

    // Abort only when the slave is still not ready on the last allowed cycle;
    // a PREADY on that same cycle completes normally.
    assign to_hit = TO_EN && (cnt_q == TO_LAST);

    // Every handshake/APB control output is a pure decode of the state register.
    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || to_hit) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            PADDR         <= '0;
            PWDATA        <= '0;
            PWRITE        <= 1'b0;
            cnt_q         <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid_i) begin
                PADDR  <= req_addr_i;
                PWDATA <= req_wdata_i;
                PWRITE <= req_we_i;
            end

            if (state_q == SETUP) begin
                cnt_q <= '0;
            end else if (state_q == ACCESS && !PREADY && !to_hit) begin
                cnt_q <= cnt_q + 16'd1;
            end

            if (state_q == ACCESS) begin
                if (PREADY) begin
                    rsp_rdata_o   <= PWRITE ? '0 : PRDATA;
                    rsp_err_o     <= PSLVERR;
                    rsp_timeout_o <= 1'b0;
                end else if (to_hit) begin
                    rsp_rdata_o   <= '0;
                    rsp_err_o     <= 1'b1;
                    rsp_timeout_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: instance a (TIMEOUT=255), instance b
// (TIMEOUT=4); both share APB/response inputs, each has its own req_valid.
module tb_apb_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_i;
    logic        req_valid_a;
    logic        req_valid_b;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    logic        req_ready_a, rsp_valid_a, rsp_err_a, rsp_to_a;
    logic        pwrite_a, psel_a, penable_a;
    logic [31:0] rsp_rdata_a, paddr_a, pwdata_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b, rsp_to_b;
    logic        pwrite_b, psel_b, penable_b;
    logic [31:0] rsp_rdata_b, paddr_b, pwdata_b;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(255)) dut_a (
        .clk_i(clk), .rstn_i(rstn_i),
        .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
        .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_a), .rsp_err_o(rsp_err_a),
        .rsp_timeout_o(rsp_to_a),
        .PADDR(paddr_a), .PWDATA(pwdata_a), .PWRITE(pwrite_a),
        .PSEL(psel_a), .PENABLE(penable_a),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut_b (
        .clk_i(clk), .rstn_i(rstn_i),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
        .req_addr_i(req_addr), .req_we_i(req_we), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b),
        .rsp_timeout_o(rsp_to_b),
        .PADDR(paddr_b), .PWDATA(pwdata_b), .PWRITE(pwrite_b),
        .PSEL(psel_b), .PENABLE(penable_b),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    logic use_b;
    wire        req_ready_s = use_b ? req_ready_b : req_ready_a;
    wire        rsp_valid_s = use_b ? rsp_valid_b : rsp_valid_a;
    wire        rsp_err_s   = use_b ? rsp_err_b   : rsp_err_a;
    wire        rsp_to_s    = use_b ? rsp_to_b    : rsp_to_a;
    wire [31:0] rsp_rdata_s = use_b ? rsp_rdata_b : rsp_rdata_a;
    wire [31:0] paddr_s     = use_b ? paddr_b     : paddr_a;
    wire [31:0] pwdata_s    = use_b ? pwdata_b    : pwdata_a;
    wire        pwrite_s    = use_b ? pwrite_b    : pwrite_a;
    wire        psel_s      = use_b ? psel_b      : psel_a;
    wire        penable_s   = use_b ? penable_b   : penable_a;

    typedef struct {
        bit          on_b;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        bit          slverr;
        int          waits;
        int          hold;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
        int          exp_pen;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_valid(input bit on_b, input bit v);
        if (on_b) req_valid_b = v;
        else      req_valid_a = v;
    endtask

    task automatic xfer(input vec_t v);
        int k;
        use_b = v.on_b;
        @(negedge clk);
        check("idle_ready", req_ready_s, 1);
        req_addr  = v.addr;
        req_we    = v.we;
        req_wdata = v.wdata;
        PRDATA    = v.prdata;
        PSLVERR   = v.slverr;
        set_valid(v.on_b, 1'b1);
        @(negedge clk);
        set_valid(v.on_b, 1'b0);
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        req_we    = ~v.we;
        check("setup_psel", psel_s, 1);
        check("setup_penable", penable_s, 0);
        check("setup_ready", req_ready_s, 0);
        check("setup_paddr", paddr_s, v.addr);
        check("setup_pwdata", pwdata_s, v.wdata);
        check("setup_pwrite", pwrite_s, v.we);
        k = 0;
        while (k < 300) begin
            @(negedge clk);
            if (!(psel_s && penable_s)) break;
            check("access_paddr", paddr_s, v.addr);
            check("access_pwdata", pwdata_s, v.wdata);
            PREADY = (k == v.waits);
            k++;
        end
        PREADY = 1'b0;
        check("access_cycles", k, v.exp_pen);
        check("rsp_valid", rsp_valid_s, 1);
        check("rsp_psel", psel_s, 0);
        check("rsp_rdata", rsp_rdata_s, v.exp_rdata);
        check("rsp_err", rsp_err_s, v.exp_err);
        check("rsp_timeout", rsp_to_s, v.exp_to);
        for (int h = 0; h < v.hold; h++) begin
            set_valid(v.on_b, 1'b1);
            PREADY = 1'b1;
            PRDATA = 32'h0BAD_0BAD;
            @(negedge clk);
            check("hold_valid", rsp_valid_s, 1);
            check("hold_rdata", rsp_rdata_s, v.exp_rdata);
            check("hold_err", rsp_err_s, v.exp_err);
            check("hold_ready", req_ready_s, 0);
            check("hold_psel", psel_s, 0);
        end
        set_valid(v.on_b, 1'b0);
        PREADY    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("done_ready", req_ready_s, 1);
        check("done_valid", rsp_valid_s, 0);
        check("done_psel", psel_s, 0);
    endtask

    vec_t vt[10];
    vec_t post;

    initial begin
        rstn_i      = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr    = '0;
        req_we      = 1'b0;
        req_wdata   = '0;
        rsp_ready   = 1'b0;
        PRDATA      = '0;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        use_b       = 1'b0;

        vt[0] = '{0, 1, 32'h8, 32'hDEAD_BEEF, 32'h5555, 0, 0, 0,
                  32'h0, 0, 0, 1};
        vt[1] = '{0, 0, 32'h4, 32'h0, 32'hA5, 0, 5, 0,
                  32'hA5, 0, 0, 6};
        vt[2] = '{0, 0, 32'h10, 32'h0, 32'h1234, 1, 0, 0,
                  32'h1234, 1, 0, 1};
        vt[3] = '{1, 0, 32'h20, 32'h0, 32'h99, 0, 100, 0,
                  32'h0, 1, 1, 4};
        vt[4] = '{1, 1, 32'h24, 32'hCAFE, 32'h99, 0, 3, 0,
                  32'h0, 0, 0, 4};
        vt[5] = '{0, 1, 32'h28, 32'h11, 32'h0, 1, 2, 0,
                  32'h0, 1, 0, 3};
        vt[6] = '{1, 0, 32'h2C, 32'h0, 32'h77, 0, 2, 0,
                  32'h77, 0, 0, 3};
        vt[7] = '{0, 0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 0, 1, 0,
                  32'hFFFF_FFFF, 0, 0, 2};
        vt[8] = '{0, 0, 32'h30, 32'h0, 32'hBB, 0, 0, 10,
                  32'hBB, 0, 0, 1};
        vt[9] = '{1, 1, 32'h34, 32'h55, 32'h66, 1, 100, 0,
                  32'h0, 1, 1, 4};
        post  = '{0, 0, 32'h44, 32'h0, 32'h3C, 0, 1, 0,
                  32'h3C, 0, 0, 2};

        #1;
        check("rst_ready_a", req_ready_a, 1);
        check("rst_ready_b", req_ready_b, 1);
        check("rst_psel", psel_a, 0);
        check("rst_penable", penable_a, 0);
        check("rst_valid", rsp_valid_a, 0);
        check("rst_paddr", paddr_a, 0);
        check("rst_rdata", rsp_rdata_a, 0);
        check("rst_err", rsp_err_a, 0);
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;

        for (int i = 0; i < 10; i++) xfer(vt[i]);

        use_b = 1'b0;
        @(negedge clk);
        req_addr    = 32'h40;
        req_we      = 1'b0;
        req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", penable_a, 1);
        #2 rstn_i = 1'b0;
        #1;
        check("mid_rst_psel", psel_a, 0);
        check("mid_rst_penable", penable_a, 0);
        check("mid_rst_valid", rsp_valid_a, 0);
        check("mid_rst_ready", req_ready_a, 1);
        @(negedge clk);
        rstn_i = 1'b1;
        PREADY = 1'b1;
        PRDATA = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", rsp_valid_a, 0);
            check("post_rst_psel", psel_a, 0);
            check("post_rst_ready", req_ready_a, 1);
        end
        PREADY = 1'b0;
        xfer(post);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
